// File: rtl/btn_pkg.sv
// Shared definitions for the pushbutton conditioning path: FSM state codes and timer counts.
package btn_pkg;

  typedef enum logic [2:0] {
    INI     = 3'd0,
    WQ      = 3'd1,
    SCEN_ST = 3'd2,
    HOLD    = 3'd3,
    MCEN_ST = 3'd4,
    RPT     = 3'd5,
    WREL    = 3'd6
  } btn_state_t;

  // 100 MHz board timing
  localparam int DEF_CNT_W           = 27;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_HOLD_CYCLES     = 50_000_000;
  localparam int DEF_REPEAT_CYCLES   = 10_000_000;

  // Short counts so simulation reaches every timeout quickly
  localparam int SIM_CNT_W           = 8;
  localparam int SIM_DEBOUNCE_CYCLES = 4;
  localparam int SIM_HOLD_CYCLES     = 10;
  localparam int SIM_REPEAT_CYCLES   = 5;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous board input.
module sync_2ff (
  input  logic Clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic ff1;

  always_ff @(posedge Clk) begin
    if (reset) begin
      ff1 <= 1'b0;
      q   <= 1'b0;
    end else begin
      ff1 <= d;
      q   <= ff1;
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: synchronize, debounce, single press pulse and optional auto-repeat.
// Auto-repeat is built only when BTN_DEBOUNCE_REPEAT_EN is defined; otherwise mcen mirrors scen.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int CNT_W           = DEF_CNT_W,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       btn_in,
  output logic       db_out,
  output logic       scen,
  output logic       mcen,
  output logic [2:0] state_out
);

  if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
    $error("btn_debounce: cycle counts must be at least 1");
  end

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef BTN_DEBOUNCE_REPEAT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

  logic             btn_s;
  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt;
  logic             cnt_run;

  sync_2ff u_sync (
    .Clk   (Clk),
    .reset (reset),
    .d     (btn_in),
    .q     (btn_s)
  );

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q <= INI;
      cnt     <= '0;
    end else begin
      state_q <= state_d;
      cnt     <= cnt_run ? cnt + CNT_W'(1) : '0;
    end
  end

  // cnt_run is raised only on paths that stay in the same state, so any
  // state change (and INI) clears the timer.
  always_comb begin
    state_d = INI;
    cnt_run = 1'b0;
    case (state_q)
      INI: state_d = btn_s ? WQ : INI;
      WQ: begin
        if (!btn_s)             state_d = INI;
        else if (cnt == DB_LAST) state_d = SCEN_ST;
        else begin
          state_d = WQ;
          cnt_run = 1'b1;
        end
      end
      SCEN_ST: state_d = HOLD;
`ifdef BTN_DEBOUNCE_REPEAT_EN
      HOLD: begin
        if (!btn_s)                state_d = WREL;
        else if (cnt == HOLD_LAST) state_d = MCEN_ST;
        else begin
          state_d = HOLD;
          cnt_run = 1'b1;
        end
      end
      MCEN_ST: state_d = RPT;
      RPT: begin
        if (!btn_s)               state_d = WREL;
        else if (cnt == RPT_LAST) state_d = MCEN_ST;
        else begin
          state_d = RPT;
          cnt_run = 1'b1;
        end
      end
`else
      // No timeout here, so the timer is left idle to avoid wrapping.
      HOLD: state_d = btn_s ? HOLD : WREL;
`endif
      WREL: begin
        if (btn_s)               state_d = HOLD;
        else if (cnt == DB_LAST) state_d = INI;
        else begin
          state_d = WREL;
          cnt_run = 1'b1;
        end
      end
      default: state_d = INI;
    endcase
  end

  assign db_out    = (state_q == SCEN_ST) || (state_q == HOLD) || (state_q == MCEN_ST) ||
                     (state_q == RPT) || (state_q == WREL);
  assign scen      = (state_q == SCEN_ST);
`ifdef BTN_DEBOUNCE_REPEAT_EN
  assign mcen      = (state_q == SCEN_ST) || (state_q == MCEN_ST);
`else
  assign mcen      = (state_q == SCEN_ST);
`endif
  assign state_out = state_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: directed press/release/reset scenarios plus random button traffic,
// each cycle compared against a deadline-based reference model.
module tb_btn_debounce;
  import btn_pkg::*;

  localparam int CNT_W = SIM_CNT_W;
  localparam int D     = SIM_DEBOUNCE_CYCLES;
  localparam int H     = SIM_HOLD_CYCLES;
  localparam int R     = SIM_REPEAT_CYCLES;
`ifdef BTN_DEBOUNCE_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  localparam int MD_IDLE  = 0;
  localparam int MD_QUAL  = 1;
  localparam int MD_PULSE = 2;
  localparam int MD_HELD  = 3;
  localparam int MD_REL   = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_in = 1'b0;
  logic       db_out, scen, mcen;
  logic [2:0] state_out;

  always #5 clk = ~clk;

  btn_debounce #(
    .CNT_W           (CNT_W),
    .DEBOUNCE_CYCLES (D),
    .HOLD_CYCLES     (H),
    .REPEAT_CYCLES   (R)
  ) dut (
    .Clk       (clk),
    .reset     (reset),
    .btn_in    (btn_in),
    .db_out    (db_out),
    .scen      (scen),
    .mcen      (mcen),
    .state_out (state_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: a 2-deep delay line and absolute-time deadlines.
  int cyc = 0;
  bit dly[2];
  int m_mode = MD_IDLE;
  int m_t = 0;
  bit m_first = 1'b0;
  bit m_rpt = 1'b0;

  function automatic void model_step(input bit b, input bit r);
    bit s;
    if (r) begin
      m_mode = MD_IDLE;
      dly[0] = 1'b0;
      dly[1] = 1'b0;
      return;
    end
    s = dly[1];
    dly[1] = dly[0];
    dly[0] = b;
    case (m_mode)
      MD_IDLE: if (s) begin m_mode = MD_QUAL; m_t = cyc; end
      MD_QUAL: begin
        if (!s) m_mode = MD_IDLE;
        else if (cyc == m_t + D) begin m_mode = MD_PULSE; m_first = 1'b1; end
      end
      MD_PULSE: begin
        m_mode = MD_HELD;
        m_rpt  = !m_first;
        m_t    = cyc + (m_first ? H : R);
      end
      MD_HELD: begin
        if (!s) begin m_mode = MD_REL; m_t = cyc; end
        else if (REP_EN && cyc == m_t) begin m_mode = MD_PULSE; m_first = 1'b0; end
      end
      default: begin
        if (s) begin m_mode = MD_HELD; m_rpt = 1'b0; m_t = cyc + H; end
        else if (cyc == m_t + D) m_mode = MD_IDLE;
      end
    endcase
  endfunction

  function automatic logic [2:0] m_state();
    case (m_mode)
      MD_IDLE:  return 3'd0;
      MD_QUAL:  return 3'd1;
      MD_PULSE: return m_first ? 3'd2 : 3'd4;
      MD_HELD:  return m_rpt ? 3'd5 : 3'd3;
      default:  return 3'd6;
    endcase
  endfunction

  // Scenario bookkeeping
  int  scen_cnt, mcen_cnt, db_hi_cnt, first_scen, db_fall;
  int  max_state;
  bit  db_prev = 1'b0;

  task automatic clear_stats();
    scen_cnt = 0; mcen_cnt = 0; db_hi_cnt = 0; first_scen = -1; db_fall = -1; max_state = 0;
  endtask

  task automatic tick(input bit b, input bit r);
    @(negedge clk);
    btn_in = b;
    reset  = r;
    @(posedge clk);
    cyc++;
    model_step(b, r);
    #1;
    check("db_out",    db_out,    (m_mode == MD_PULSE || m_mode == MD_HELD || m_mode == MD_REL));
    check("scen",      scen,      (m_mode == MD_PULSE && m_first));
    check("mcen",      mcen,      (m_mode == MD_PULSE));
    check("state_out", state_out, m_state());
    if (scen === 1'b1) begin
      scen_cnt++;
      if (first_scen < 0) first_scen = cyc;
    end
    if (mcen === 1'b1) mcen_cnt++;
    if (db_out === 1'b1) db_hi_cnt++;
    if (db_prev && db_out === 1'b0) db_fall = cyc;
    db_prev = (db_out === 1'b1);
    if (int'(state_out) > max_state) max_state = int'(state_out);
  endtask

  // Reset with the button already high, then count edges to the press pulse.
  task automatic clean_press(input string tag);
    int r0;
    clear_stats();
    tick(1'b1, 1'b1);
    r0 = cyc;
    repeat (D + 8) tick(1'b1, 1'b0);
    check(tag, first_scen - r0, D + 3);
    check({tag, "_scen_cnt"}, scen_cnt, 1);
    repeat (D + 6) tick(1'b0, 1'b0);
  endtask

  initial begin
    int f_edge, seg_len, lvl;
    bit pat[5];

    repeat (3) tick(1'b0, 1'b1);
    check("reset_db",    db_out,    0);
    check("reset_state", state_out, 0);

    clean_press("clean_latency");

    // Press bounce: 1,0,1,1,0 then stable high
    tick(1'b0, 1'b1);
    clear_stats();
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    foreach (pat[i]) tick(pat[i], 1'b0);
    tick(1'b1, 1'b0);
    f_edge = cyc;
    check("bounce_no_early_scen", scen_cnt, 0);
    repeat (D + 6) tick(1'b1, 1'b0);
    check("bounce_scen_latency", first_scen - f_edge, D + 2);
    check("bounce_scen_cnt", scen_cnt, 1);

    // Release bounce from HOLD: 0,1,0 then low
    repeat (2) tick(1'b1, 1'b0);
    clear_stats();
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    f_edge = cyc;
    repeat (D + 6) tick(1'b0, 1'b0);
    check("rel_db_fall", db_fall - f_edge, D + 2);
    check("rel_no_scen", scen_cnt, 0);

    // Auto-repeat window: scen edge plus the following 40 edges
    tick(1'b0, 1'b1);
    clear_stats();
    for (int i = 0; i < 20 && first_scen < 0; i++) tick(1'b1, 1'b0);
    check("rpt_scen_seen", first_scen >= 0, 1);
    repeat (40) tick(1'b1, 1'b0);
    check("rpt_mcen_cnt", mcen_cnt, REP_EN ? 6 : 1);
    check("rpt_scen_cnt", scen_cnt, 1);
    repeat (D + 6) tick(1'b0, 1'b0);

    // Reset during WQ with cnt at 2
    tick(1'b0, 1'b1);
    repeat (5) tick(1'b1, 1'b0);
    check("wq_before_reset", state_out, 1);
    tick(1'b1, 1'b1);
    check("wq_reset_state", state_out, 0);
    check("wq_reset_db", db_out, 0);
    clean_press("after_wq_reset_latency");

    // Reset while held long enough to be repeating
    tick(1'b0, 1'b1);
    clear_stats();
    repeat (D + 3 + H + 6) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    check("rpt_reset_state", state_out, 0);
    check("rpt_reset_mcen", mcen, 0);
    clean_press("after_rpt_reset_latency");

    // Short glitch
    tick(1'b0, 1'b1);
    clear_stats();
    repeat (3) tick(1'b1, 1'b0);
    repeat (D + 6) tick(1'b0, 1'b0);
    check("glitch_max_state", max_state, 1);
    check("glitch_db", db_hi_cnt, 0);
    check("glitch_mcen", mcen_cnt, 0);

    // Random traffic: mix of bounce-length and long segments, rare resets
    for (int k = 0; k < 300; k++) begin
      lvl = int'($urandom_range(0, 1));
      seg_len = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(6, 40));
      for (int j = 0; j < seg_len; j++) tick(lvl[0], $urandom_range(0, 199) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
